// File: rtl/csr_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csr_commit_arbiter
// Purpose  : Round-robin, group-locking arbiter that queues CSR-update records
//            from commit taps and forwards them to the cosim CSR comparator.
//            Optional macro CSR_COUNTER_FILTER_EN drops counter CSR records.
// Revision : 1.0 - initial release
// ============================================================================
module csr_commit_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 12,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*ID_W-1:0]      req_id_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    input  logic                         flush_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ID_W-1:0]              out_id_o,
    output logic [DATA_W-1:0]            out_data_o,
    output logic                         out_last_o,
    output logic [$clog2(NUM_REQ)-1:0]   out_src_o,
    output logic [$clog2(DEPTH):0]       fifo_count_o,
    output logic [15:0]                  filt_cnt_o
);

    localparam int c_src_w = $clog2(NUM_REQ);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

    localparam logic [0:0] c_st_open   = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic                w_locked;
    logic [c_src_w-1:0]  r_lock_src;
    logic [c_src_w-1:0]  r_rr_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  r_wr_ptr;

    logic [ID_W-1:0]     r_mem_id   [DEPTH];
    logic [DATA_W-1:0]   r_mem_data [DEPTH];
    logic                r_mem_last [DEPTH];
    logic [c_src_w-1:0]  r_mem_src  [DEPTH];

    logic                w_gnt_hit;
    logic [c_src_w-1:0]  w_gnt_idx;
    logic [c_src_w-1:0]  w_rr_next;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_out_valid;
    logic                w_is_counter;
    logic [ID_W-1:0]     w_sel_id;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_last;

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_open;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = c_st_open;
        end else if (w_accept) begin
            w_state_next = w_sel_last ? c_st_open : c_st_locked;
        end
    end

    always_comb begin
        w_locked = (r_state == c_st_locked);
    end

    // ------------------------------------------------------------------
    // Grant selection: locked owner, else first valid at or after rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        logic [c_src_w-1:0] w_scan;
        w_scan    = '0;
        w_gnt_hit = 1'b0;
        w_gnt_idx = r_rr_ptr;
        if (w_locked) begin
            w_gnt_idx = r_lock_src;
            w_gnt_hit = req_valid_i[r_lock_src];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_scan = c_src_w'((int'(r_rr_ptr) + i) % NUM_REQ);
                if (!w_gnt_hit && req_valid_i[w_scan]) begin
                    w_gnt_hit = 1'b1;
                    w_gnt_idx = w_scan;
                end
            end
        end
    end

    always_comb begin
        w_rr_next = c_src_w'((int'(w_gnt_idx) + 1) % NUM_REQ);
    end

    // No push-on-pop at full: acceptance depends only on registered occupancy.
    always_comb begin
        w_accept = !rst && !flush_i && (r_count < c_depth_cnt) && w_gnt_hit;
    end

    always_comb begin
        req_ready_o = '0;
        if (w_accept) begin
            req_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_id   = '0;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (c_src_w'(k) == w_gnt_idx) begin
                w_sel_id   = req_id_i[k*ID_W +: ID_W];
                w_sel_data = req_data_i[k*DATA_W +: DATA_W];
                w_sel_last = req_last_i[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter-CSR filter
    // ------------------------------------------------------------------
`ifdef CSR_COUNTER_FILTER_EN
    logic [15:0] r_filt_cnt;

    always_comb begin
        w_is_counter = w_sel_id inside {
            ID_W'(12'hc00), ID_W'(12'hc01), ID_W'(12'hc02),
            ID_W'(12'hc80), ID_W'(12'hc81), ID_W'(12'hc82),
            ID_W'(12'hb00), ID_W'(12'hb02), ID_W'(12'hb80), ID_W'(12'hb82)};
    end

    // Survives flush so the consumer can account for dropped counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_cnt <= 16'h0000;
        end else if (w_accept && w_is_counter && (r_filt_cnt != 16'hffff)) begin
            r_filt_cnt <= r_filt_cnt + 16'h0001;
        end
    end

    always_comb begin
        filt_cnt_o = rst ? 16'h0000 : r_filt_cnt;
    end
`else
    always_comb begin
        w_is_counter = 1'b0;
        filt_cnt_o   = 16'h0000;
    end
`endif

    always_comb begin
        w_push      = w_accept && !w_is_counter;
        w_out_valid = !rst && (r_count != '0);
        w_pop       = w_out_valid && out_ready_i && !flush_i;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rr_ptr   <= '0;
            r_lock_src <= '0;
        end else if (flush_i) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_accept) begin
                if (w_sel_last) begin
                    r_rr_ptr <= w_rr_next;
                end else begin
                    r_lock_src <= w_gnt_idx;
                end
            end
        end
    end

    // Storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr_ptr]   <= w_sel_id;
            r_mem_data[r_wr_ptr] <= w_sel_data;
            r_mem_last[r_wr_ptr] <= w_sel_last;
            r_mem_src[r_wr_ptr]  <= w_gnt_idx;
        end
    end

    // ------------------------------------------------------------------
    // Output port
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_o  = w_out_valid;
        out_id_o     = w_out_valid ? r_mem_id[r_rd_ptr]   : '0;
        out_data_o   = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
        out_last_o   = w_out_valid ? r_mem_last[r_rd_ptr] : 1'b0;
        out_src_o    = w_out_valid ? r_mem_src[r_rd_ptr]  : '0;
        fifo_count_o = rst ? '0 : r_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_commit_arbiter
// Purpose  : Self-checking bench for csr_commit_arbiter (vector table plus
//            corner sequences, with an output scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_commit_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid_i;
    logic [1:0]   req_ready_o;
    logic [23:0]  req_id_i;
    logic [127:0] req_data_i;
    logic [1:0]   req_last_i;
    logic         flush_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [11:0]  out_id_o;
    logic [63:0]  out_data_o;
    logic         out_last_o;
    logic [0:0]   out_src_o;
    logic [3:0]   fifo_count_o;
    logic [15:0]  filt_cnt_o;

    csr_commit_arbiter #(
        .NUM_REQ (2),
        .ID_W    (12),
        .DATA_W  (64),
        .DEPTH   (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_id_i     (req_id_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .flush_i      (flush_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_id_o     (out_id_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .out_src_o    (out_src_o),
        .fifo_count_o (fifo_count_o),
        .filt_cnt_o   (filt_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] id;
        logic [63:0] data;
        logic        last;
        logic [0:0]  src;
    } rec_t;

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  last;
        logic [11:0] id0;
        logic [11:0] id1;
        logic        ordy;
        logic [1:0]  exp_rdy;
        logic [3:0]  exp_cnt;
    } vec_t;

    rec_t sb_q[$];
    vec_t vecs[12];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input int k, input logic [11:0] id);
        return {8'hD0 + 8'(k), 44'h0, id};
    endfunction

    task automatic drive(input logic [1:0] vld, input logic [1:0] lst, input logic [11:0] i0,
                         input logic [11:0] i1, input logic ordy, input logic fl);
        req_valid_i = vld;
        req_last_i  = lst;
        req_id_i    = {i1, i0};
        req_data_i  = {data_of(1, i1), data_of(0, i0)};
        out_ready_i = ordy;
        flush_i     = fl;
    endtask

    task automatic push_exp(input int k, input logic [11:0] id, input logic lst);
        rec_t r;
        r.id   = id;
        r.data = data_of(k, id);
        r.last = lst;
        r.src  = 1'(k);
        sb_q.push_back(r);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        drive(2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fifo_count_o == 4'd0) break;
        end
        chk({nm, "_drain_cnt"}, fifo_count_o, 0);
        chk({nm, "_drain_oval"}, out_valid_o, 0);
        next_cycle();
    endtask

    // Scoreboard: a transfer is what the next rising edge will take.
    always @(negedge clk) begin
        if (!rst && !flush_i && out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected actual_id=%h required=none", out_id_o);
            end else begin
                rec_t e;
                e = sb_q.pop_front();
                chk("sb_id", out_id_o, e.id);
                chk("sb_data", out_data_o, e.data);
                chk("sb_last", out_last_o, e.last);
                chk("sb_src", out_src_o, e.src);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b11, 2'b11, 12'h101, 12'h201, 1'b1, 2'b01, 4'd0};
        vecs[1]  = '{2'b11, 2'b11, 12'h102, 12'h202, 1'b1, 2'b10, 4'd1};
        vecs[2]  = '{2'b11, 2'b11, 12'h103, 12'h203, 1'b1, 2'b01, 4'd1};
        vecs[3]  = '{2'b11, 2'b11, 12'h104, 12'h204, 1'b1, 2'b10, 4'd1};
        vecs[4]  = '{2'b00, 2'b11, 12'h000, 12'h000, 1'b1, 2'b00, 4'd1};
        vecs[5]  = '{2'b00, 2'b11, 12'h000, 12'h000, 1'b1, 2'b00, 4'd0};
        vecs[6]  = '{2'b11, 2'b10, 12'h300, 12'h7a0, 1'b1, 2'b01, 4'd0};
        vecs[7]  = '{2'b11, 2'b10, 12'h341, 12'h7a0, 1'b1, 2'b01, 4'd1};
        vecs[8]  = '{2'b11, 2'b11, 12'h342, 12'h7a0, 1'b1, 2'b01, 4'd1};
        vecs[9]  = '{2'b10, 2'b11, 12'h000, 12'h7a0, 1'b1, 2'b10, 4'd1};
        vecs[10] = '{2'b00, 2'b11, 12'h000, 12'h000, 1'b1, 2'b00, 4'd1};
        vecs[11] = '{2'b00, 2'b11, 12'h000, 12'h000, 1'b1, 2'b00, 4'd0};

        // Reset: requests present but nothing may be accepted or shown.
        rst = 1'b1;
        drive(2'b11, 2'b11, 12'h0aa, 12'h0bb, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rdy", req_ready_o, 0);
        chk("rst_oval", out_valid_o, 0);
        chk("rst_cnt", fifo_count_o, 0);
        chk("rst_filt", filt_cnt_o, 0);
        next_cycle();
        rst = 1'b0;
        drive(2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_cnt", fifo_count_o, 0);
        chk("post_rst_oval", out_valid_o, 0);
        next_cycle();

        // Round-robin fairness and group lock
        for (int r = 0; r < 12; r++) begin
            drive(vecs[r].vld, vecs[r].last, vecs[r].id0, vecs[r].id1, vecs[r].ordy, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", r), req_ready_o, vecs[r].exp_rdy);
            chk($sformatf("vec%0d_cnt", r), fifo_count_o, vecs[r].exp_cnt);
            chk($sformatf("vec%0d_oval", r), out_valid_o, vecs[r].exp_cnt != 4'd0);
            if (vecs[r].exp_rdy[0]) push_exp(0, vecs[r].id0, vecs[r].last[0]);
            if (vecs[r].exp_rdy[1]) push_exp(1, vecs[r].id1, vecs[r].last[1]);
            next_cycle();
        end

        // Full backpressure
        for (int i = 0; i < 9; i++) begin
            drive(2'b01, 2'b01, 12'(12'h400 + i), 12'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (i < 8) begin
                chk($sformatf("full%0d_rdy", i), req_ready_o, 2'b01);
                chk($sformatf("full%0d_cnt", i), fifo_count_o, 64'(i));
                push_exp(0, 12'(12'h400 + i), 1'b1);
            end else begin
                chk("full_9th_rdy", req_ready_o, 2'b00);
                chk("full_9th_cnt", fifo_count_o, 8);
            end
            next_cycle();
        end
        drive(2'b01, 2'b01, 12'h408, 12'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("full_pop_rdy", req_ready_o, 2'b00);
        chk("full_pop_cnt", fifo_count_o, 8);
        next_cycle();
        @(negedge clk);
        chk("full_reopen_rdy", req_ready_o, 2'b01);
        chk("full_reopen_cnt", fifo_count_o, 7);
        push_exp(0, 12'h408, 1'b1);
        next_cycle();
        drain("full");

        // Flush mid-group with requester 1 locked
        drive(2'b10, 2'b00, 12'h5ff, 12'h500, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_g0_rdy", req_ready_o, 2'b10);
        next_cycle();
        drive(2'b11, 2'b00, 12'h5ff, 12'h501, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_g1_rdy", req_ready_o, 2'b10);
        next_cycle();
        drive(2'b11, 2'b00, 12'h5ff, 12'h502, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_g2_rdy", req_ready_o, 2'b10);
        next_cycle();
        drive(2'b11, 2'b00, 12'h5ff, 12'h503, 1'b1, 1'b1);
        @(negedge clk);
        chk("flush_cyc_rdy", req_ready_o, 2'b00);
        chk("flush_cyc_cnt", fifo_count_o, 3);
        next_cycle();
        drive(2'b01, 2'b01, 12'h510, 12'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_after_cnt", fifo_count_o, 0);
        chk("flush_after_oval", out_valid_o, 0);
        chk("flush_after_id", out_id_o, 0);
        chk("flush_after_rdy", req_ready_o, 2'b01);
        push_exp(0, 12'h510, 1'b1);
        next_cycle();
        drain("flush");

        // Reset with five entries buffered and a lock held
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 2'b01, 12'(12'h600 + i), 12'h0, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("rfill%0d_rdy", i), req_ready_o, 2'b01);
            next_cycle();
        end
        drive(2'b10, 2'b00, 12'h0, 12'h610, 1'b0, 1'b0);
        @(negedge clk);
        chk("rfill_lock_rdy", req_ready_o, 2'b10);
        chk("rfill_lock_cnt", fifo_count_o, 4);
        next_cycle();
        rst = 1'b1;
        drive(2'b11, 2'b11, 12'h620, 12'h621, 1'b1, 1'b0);
        @(negedge clk);
        chk("rmid_oval", out_valid_o, 0);
        chk("rmid_rdy", req_ready_o, 2'b00);
        chk("rmid_cnt", fifo_count_o, 0);
        chk("rmid_id", out_id_o, 0);
        chk("rmid_data", out_data_o, 0);
        next_cycle();
        rst = 1'b0;
        drive(2'b11, 2'b11, 12'h620, 12'h621, 1'b0, 1'b0);
        @(negedge clk);
        chk("rpost_cnt", fifo_count_o, 0);
        chk("rpost_oval", out_valid_o, 0);
        chk("rpost_rdy", req_ready_o, 2'b01);
        push_exp(0, 12'h620, 1'b1);
        next_cycle();
        drain("rmid");

        // Counter-CSR records
        drive(2'b01, 2'b00, 12'hc00, 12'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("filt_c00_rdy", req_ready_o, 2'b01);
`ifndef CSR_COUNTER_FILTER_EN
        push_exp(0, 12'hc00, 1'b0);
`endif
        next_cycle();
        drive(2'b01, 2'b01, 12'hb02, 12'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("filt_b02_rdy", req_ready_o, 2'b01);
`ifndef CSR_COUNTER_FILTER_EN
        push_exp(0, 12'hb02, 1'b1);
`endif
        next_cycle();
        drive(2'b10, 2'b10, 12'h0, 12'h305, 1'b1, 1'b0);
        @(negedge clk);
        chk("filt_305_rdy", req_ready_o, 2'b10);
        push_exp(1, 12'h305, 1'b1);
        next_cycle();
        drain("filt");
`ifdef CSR_COUNTER_FILTER_EN
        chk("filt_cnt", filt_cnt_o, 2);
`else
        chk("filt_cnt", filt_cnt_o, 0);
`endif

        chk("sb_leftover", 64'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
